// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Field positions follow the RV32 base encoding.
package ifq_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam int OP_LSB = 0;
    localparam int OP_W   = 7;
    localparam int F3_LSB = 12;
    localparam int F3_W   = 3;
    localparam int F7_LSB = 25;
    localparam int F7_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle: instruction memory request/response and decode handshake.
// master = fetch queue, slave = memory/decode environment.
interface instr_fetch_queue_if import ifq_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [OP_W-1:0] Op;
    logic [F3_W-1:0] funct3;
    logic [F7_W-1:0] funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc, Op, funct3, funct7,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc, Op, funct3, funct7,
        output instr_ready
    );

endinterface

// File: rtl/ifq_fifo.sv
// Power-of-two circular buffer of {instruction, pc} entries.
// Flush empties it in one cycle; memory contents need no reset.
module ifq_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC, single-outstanding request FSM and decode-facing queue.
// Define IFQ_PERF_EN to add the saturating redirect-cycle counter output.
module instr_fetch_queue import ifq_pkg::*; #(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    instr_fetch_queue_if.master      bus
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]              perf_redirect_cnt
`endif
);

    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    fetch_state_t      state;
    logic [XLEN-1:0]   fpc;
    logic [XLEN-1:0]   req_pc;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              accept;
    logic              push;
    logic              pop;

    // Credit check: a request only leaves when its response has a slot.
    assign bus.imem_req_valid = rst && (state == IDLE) &&
                                (count < FULL) && !redirect;
    assign bus.imem_req_addr  = fpc;

    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    assign push   = (state == WAIT) && bus.imem_rsp_valid && !redirect;
    assign pop    = bus.instr_valid && bus.instr_ready && !redirect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            fpc    <= RESET_PC;
            req_pc <= '0;
        end else if (redirect) begin
            fpc <= redirect_pc & ~XLEN'(3);
            unique case (state)
                WAIT, DROP: state <= bus.imem_rsp_valid ? IDLE : DROP;
                default:    state <= IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= WAIT;
                        fpc    <= fpc + XLEN'(4);
                        req_pc <= fpc;
                    end
                end
                WAIT, DROP: begin
                    if (bus.imem_rsp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifq_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({bus.imem_rsp_data, req_pc}),
        .dout  (head),
        .count (count)
    );

    assign bus.instr_valid = (count != '0);
    assign bus.instr    = bus.instr_valid ? head[2*XLEN-1:XLEN] : '0;
    assign bus.instr_pc = bus.instr_valid ? head[XLEN-1:0] : '0;
    assign bus.Op       = bus.instr[OP_LSB +: OP_W];
    assign bus.funct3   = bus.instr[F3_LSB +: F3_W];
    assign bus.funct7   = bus.instr[F7_LSB +: F7_W];

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst)
            perf_redirect_cnt <= '0;
        else if (redirect && perf_redirect_cnt != 32'hFFFF_FFFF)
            perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios then random traffic.
// Stimulus predicts queue contents; a monitor compares the decode side.
module tb_instr_fetch_queue;
    import ifq_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFQ_PERF_EN
    logic [31:0] perf;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.XLEN(32)) bus ();

    instr_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
`ifdef IFQ_PERF_EN
        ,
        .perf_redirect_cnt (perf)
`endif
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } item_t;

    item_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    mon_en = 0;

    // reference model
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_fpc;
    logic [31:0] m_req_pc;
    logic [31:0] m_perf;

    // memory environment
    bit          mem_busy  = 0;
    int          mem_cnt   = 0;
    int          mem_lat   = 1;
    bit          mem_fixed = 0;
    logic [31:0] mem_data  = '0;
    bit          spur_en   = 0;
    bit          rsp_now   = 0;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // rd_mode: 0 none, 1 redirect, 2 redirect only if a response is due
    task automatic cycle(input bit rs, input bit rdy, input int rd_mode,
                         input logic [31:0] rpc, input bit ir);
        bit rv;
        bit rd;
        bit acc;
        bit exp_rv;
        @(negedge clk);
        rv = mem_busy && mem_cnt == 1;
        if (!mem_busy && spur_en && $urandom_range(0, 9) == 0) rv = 1;
        rd = (rd_mode == 1) || (rd_mode == 2 && rv);
        rsp_now = rv;
        rst = rs;
        redirect = rd;
        redirect_pc = rpc;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = (rv && mem_fixed) ? mem_data : $urandom;
        bus.instr_ready = ir;
        #1;
        exp_rv = rs && !m_busy && exp_q.size() < DEPTH && !rd;
        if (mon_en) begin
            chk("req_valid", bus.imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", bus.imem_req_addr, m_fpc);
        end
        acc = bus.imem_req_valid && rdy;
        #2;
        if (!rs) begin
            exp_q.delete();
            m_busy = 0;
            m_drop = 0;
            m_fpc  = RST_PC;
            m_perf = 0;
        end else if (rd) begin
            exp_q.delete();
            m_fpc = rpc & 32'hFFFF_FFFC;
            if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
            if (m_busy) begin
                if (rv) begin
                    m_busy = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end
        end else if (exp_rv && rdy) begin
            m_busy   = 1;
            m_drop   = 0;
            m_req_pc = m_fpc;
            m_fpc    = m_fpc + 32'd4;
        end else if (m_busy && rv) begin
            if (!m_drop)
                exp_q.push_back(item_t'{word: bus.imem_rsp_data,
                                        pc: m_req_pc});
            m_busy = 0;
            m_drop = 0;
        end
        if (mem_busy) begin
            if (mem_cnt == 1) mem_busy = 0;
            else mem_cnt--;
        end
        if (acc) begin
            mem_busy = 1;
            mem_cnt  = mem_lat;
        end
    endtask

    task automatic reset_dut();
        repeat (2) cycle(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 8 && mem_busy; i++) cycle(1, 0, 0, 32'h0, 0);
    endtask

    // monitor: compares the queue head against the scoreboard every cycle
    always @(negedge clk) begin
        item_t it;
        #2;
        if (mon_en) begin
            chk("instr_valid", bus.instr_valid, exp_q.size() != 0);
            if (!bus.instr_valid) begin
                chk("idle_zero", {bus.instr, bus.instr_pc}, 64'h0);
                chk("idle_dec_zero", {bus.Op, bus.funct3, bus.funct7}, 64'h0);
            end else if (exp_q.size() != 0) begin
                it = exp_q[0];
                chk("instr", bus.instr, it.word);
                chk("instr_pc", bus.instr_pc, it.pc);
                chk("Op", bus.Op, it.word[6:0]);
                chk("funct3", bus.funct3, it.word[14:12]);
                chk("funct7", bus.funct7, it.word[31:25]);
                if (bus.instr_ready && !redirect) void'(exp_q.pop_front());
            end
            chk("count_le_depth", int'(dut.u_fifo.count) <= DEPTH, 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 0;

        cycle(0, 0, 0, 32'h0, 0);
        mon_en = 1;
        cycle(0, 0, 0, 32'h0, 0);
        chk("reset_instr_valid", bus.instr_valid, 0);

        // first fetch after release, 1-cycle response
        mem_lat = 1;
        mem_fixed = 1;
        mem_data = 32'h00A0_0093;
        cycle(1, 1, 0, 32'h0, 0);
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        chk("first_instr_valid", bus.instr_valid, 1);
        chk("first_instr", bus.instr, 32'h00A0_0093);
        chk("first_pc", bus.instr_pc, 32'h0);
        chk("first_op", bus.Op, 7'h13);
        chk("first_f3f7", {bus.funct3, bus.funct7}, 10'h0);

        // stalled decode fills both slots, fetch must stop
        mem_data = 32'h00B0_0113;
        cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h0, 0);
        repeat (3) begin
            cycle(1, 1, 0, 32'h0, 0);
            chk("full_hold_req", bus.imem_req_valid, 0);
            chk("full_head_pc", bus.instr_pc, 32'h0);
        end
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 0);
        chk("after_pop_req", bus.imem_req_valid, 1);
        chk("after_pop_addr", bus.imem_req_addr, 32'h8);
        chk("after_pop_pc", bus.instr_pc, 32'h4);
        mem_fixed = 0;
        reset_dut();

        // redirect while waiting; late response must be dropped
        mem_lat = 4;
        cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 0, 1, 32'h103, 0);
        repeat (3) cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        chk("drop_req_valid", bus.imem_req_valid, 1);
        chk("drop_req_addr", bus.imem_req_addr, 32'h100);
        chk("drop_empty", bus.instr_valid, 0);
        reset_dut();

        // redirect, response and pop in the same cycle
        mem_lat = 1;
        cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        mem_lat = 2;
        cycle(1, 1, 0, 32'h0, 0);
        hit = 0;
        for (int i = 0; i < 6 && !hit; i++) begin
            cycle(1, 0, 2, 32'h0000_2000, 1);
            hit = rsp_now;
        end
        chk("rsp_redirect_seen", hit, 1);
        cycle(1, 0, 0, 32'h0, 0);
        chk("rr_req_valid", bus.imem_req_valid, 1);
        chk("rr_req_addr", bus.imem_req_addr, 32'h2000);
        chk("rr_empty", bus.instr_valid, 0);
        reset_dut();

        // fetch PC wrap, with low redirect bits forced to zero
        mem_lat = 1;
        cycle(1, 0, 1, 32'hFFFF_FFFE, 0);
        cycle(1, 1, 0, 32'h0, 0);
        chk("wrap_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        chk("wrap_next_addr", bus.imem_req_addr, 32'h0);
        chk("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
        reset_dut();

        // reset in WAIT; response lands after release
        mem_lat = 3;
        cycle(1, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        chk("rst_wait_req", bus.imem_req_valid, 1);
        chk("rst_wait_addr", bus.imem_req_addr, RST_PC);
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 0, 0, 32'h0, 0);
        chk("rst_wait_empty", bus.instr_valid, 0);
`ifdef IFQ_PERF_EN
        chk("perf_after_reset", perf, 32'h0);
`endif

        // random traffic
        spur_en = 1;
        repeat (3000) begin
            int rdm;
            rdm = 0;
            if ($urandom_range(0, 19) == 0) rdm = 1;
            else if ($urandom_range(0, 29) == 0) rdm = 2;
            mem_lat = $urandom_range(1, 3);
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                  rdm, $urandom, $urandom_range(0, 2) != 0);
        end
`ifdef IFQ_PERF_EN
        chk("perf_count", perf, m_perf);
`endif
        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, 32, address and instruction width.
REQ-002 SHALL have parameter DEPTH, 2, queue entries (power of two, at least 2).
REQ-003 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address.
REQ-004 One clock; reset is synchronous and active-low. Ports: clk  in  1  clock; rst  in  1  sync active-low reset.
REQ-005 SHALL have ports imem_req_valid  out  1  fetch request; imem_req_ready  in  1  memory accepts request; imem_req_addr  out  XLEN  word address, bits [1:0]=00.
REQ-006 SHALL have ports imem_rsp_valid  in  1  response strobe; imem_rsp_data  in  XLEN  instruction word.
REQ-007 SHALL have ports redirect  in  1  taken branch/PCSrc; redirect_pc  in  XLEN  new fetch address.
REQ-008 SHALL have ports instr_valid  out  1  head valid; instr_ready  in  1  decode consumes; instr  out  XLEN  head word; instr_pc  out  XLEN  head PC.
REQ-009 SHALL have ports Op  out  7  instr[6:0]; funct3  out  3  instr[14:12]; funct7  out  7  instr[31:25].

Function
REQ-010 SHALL hold fetch PC register fpc; request accepted when imem_req_valid and imem_req_ready are both high; fpc += 4 on acceptance (wraps modulo 2^XLEN).
REQ-011 SHALL allow at most one outstanding request; imem_req_valid = (state==IDLE) and (count < DEPTH) and not redirect.
REQ-012 SHALL run FSM IDLE, WAIT, DROP: IDLE->WAIT on acceptance; WAIT->IDLE on imem_rsp_valid; WAIT->DROP on redirect without a same-cycle response; DROP->IDLE on imem_rsp_valid.
REQ-013 SHALL push {imem_rsp_data, PC of request} into the queue on imem_rsp_valid in WAIT only; responses in IDLE or DROP are discarded.
REQ-014 SHALL allow minimum response latency of 1 cycle after acceptance; the queued instruction is visible on instr_valid the cycle after the response.
REQ-015 SHALL pop the head when instr_valid and instr_ready are both high; simultaneous push and pop leave count unchanged.
REQ-016 SHALL drive instr, instr_pc, Op, funct3 and funct7 to zero when instr_valid is low.
REQ-017 On redirect: count<=0, fpc<=redirect_pc with bits [1:0] forced to 00, WAIT->DROP; redirect wins over any same-cycle push, pop or acceptance.
REQ-018 Redirect in WAIT with a same-cycle response: response discarded, state->IDLE.
REQ-019 Redirect in DROP: state remains DROP and fpc takes the newest redirect_pc.
REQ-020 SHALL never push when count==DEPTH; the credit rule in REQ-011 guarantees this, and a bench assertion checks it.

Reset
REQ-021 rst low at a clk edge: fpc=RESET_PC, count=0, state=IDLE, instr_valid=0, imem_req_valid=0, all data outputs 0.
REQ-022 A response arriving after mid-operation reset SHALL be discarded because state is IDLE.
REQ-023 The first request SHALL assert in the first cycle after rst goes high.

Configuration
REQ-024 Macro IFQ_PERF_EN: when defined, adds output perf_redirect_cnt (32 bits), which counts redirect cycles, saturates at 32'hFFFF_FFFF and resets to 0. Without the macro, the port and counter are absent and all other behaviour is identical.

Structure
REQ-025 Package ifq_pkg SHALL hold the XLEN default, the opcode/funct3/funct7 bit-position constants and the FSM state enum (IDLE, WAIT, DROP).
REQ-026 Storage SHALL be one sub-module ifq_fifo (DEPTH entries of 2*XLEN bits, push/pop/flush, count); the FSM and fpc stay in instr_fetch_queue.

Verification
REQ-027 Reset release, imem_req_ready=1, 1-cycle response 32'h00A00093 -> request at addr 0x0, then instr_valid=1, instr_pc=0x0, Op=7'h13, funct3=0, funct7=0.
REQ-028 instr_ready=0 with DEPTH=2 -> two words queued (PCs 0x0, 0x4); imem_req_valid stays 0 until a pop; count never exceeds 2.
REQ-029 redirect with redirect_pc=0x103 while in WAIT, response returns 3 cycles later -> response discarded, queue empty, next request addr 0x100.
REQ-030 Redirect and response in the same cycle, plus a pop of a full queue -> queue empty, state IDLE, next request addr = redirect_pc.
REQ-031 fpc=0xFFFF_FFFC, request accepted -> next request addr 0x0000_0000.
REQ-032 rst low while in WAIT, response arrives after release -> response ignored, first request addr RESET_PC; with IFQ_PERF_EN, perf_redirect_cnt=0.
